compl_serial: RTL and testbench

//  Bit-serial conditional complementer, parametrised successor to the 4-bit combinational compl1.

---
 rtl/compl_serial_pkg.sv | 32 +++
 rtl/compl_serial_if.sv | 33 +++
 rtl/compl_serial_bit_cell.sv | 29 ++
 rtl/compl_serial.sv | 106 ++++++++++
 tb/tb_compl_serial.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/compl_serial_pkg.sv
// compl_pkg: shared definitions for the bit-serial conditional complementer.
//   state_e    - FSM encoding (IDLE=0, RUN=1), also exported on the debug port
//   WIDTH_MAX  - widest operand any instance may use
//   compl_ref  - word-level golden function (pass / one's / two's complement)
package compl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int WIDTH_MAX = 32;

    // Word-level result for an operand of 'width' bits, computed arithmetically
    // rather than bit-serially. 64-bit intermediates avoid a shift by 32.
    function automatic logic [WIDTH_MAX-1:0] compl_ref(input logic [WIDTH_MAX-1:0] inp,
                                                       input logic cpl,
                                                       input logic tc,
                                                       input int width);
        logic [63:0] mask;
        logic [63:0] val;
        mask = (64'd1 << width) - 64'd1;
        val  = {32'd0, inp} & mask;
        if (!cpl)
            compl_ref = val[WIDTH_MAX-1:0];
        else if (!tc)
            compl_ref = WIDTH_MAX'(~val & mask);
        else
            compl_ref = WIDTH_MAX'((64'd0 - val) & mask);
    endfunction

endpackage

// File: rtl/compl_serial_if.sv
// compl_serial_if: request/result bundle of compl_serial.
//   start/inp/cpl/tc  - request, driven by the master
//   out/busy/done/ovf - result and status, driven by the slave
//   state             - FSM state exported for observation
// Handshake: a request is taken on a rising clk edge where start=1 and
// busy=0; inp/cpl/tc are sampled only on that edge. done is a one-cycle
// pulse after which out/ovf stay valid until the next done.
interface compl_serial_if #(
    parameter int WIDTH = 8
);
    import compl_pkg::*;

    logic             start;
    logic [WIDTH-1:0] inp;
    logic             cpl;
    logic             tc;
    logic [WIDTH-1:0] out;
    logic             busy;
    logic             done;
    logic             ovf;
    state_e           state;

    modport master (
        output start, inp, cpl, tc,
        input  out, busy, done, ovf, state
    );

    modport slave (
        input  start, inp, cpl, tc,
        output out, busy, done, ovf, state
    );

endinterface

// File: rtl/compl_serial_bit_cell.sv
// compl_bit_cell: one bit of the serial complement step (combinational).
//   b_i        - current operand bit (LSB-first)
//   seen_i     - a 1 has already been seen in lower bits
//   cpl_i/tc_i - complement enable / two's-complement select
//   obit_o     - result bit
//   seen_nxt_o - updated seen flag
module compl_bit_cell (
    input  logic b_i,
    input  logic seen_i,
    input  logic cpl_i,
    input  logic tc_i,
    output logic obit_o,
    output logic seen_nxt_o
);
    // Two's complement serially: copy bits up to and including the first 1,
    // invert everything above it.
    always_comb begin
        obit_o = b_i;
        if (cpl_i) begin
            if (!tc_i)
                obit_o = ~b_i;
            else
                obit_o = seen_i ? ~b_i : b_i;
        end
    end

    assign seen_nxt_o = seen_i | b_i;

endmodule

// File: rtl/compl_serial.sv
// compl_serial: bit-serial conditional complementer (pass / one's / two's).
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - compl_serial_if.slave: start/inp/cpl/tc in, out/busy/done/ovf/state out
// An accepted operand is shifted out LSB-first, one bit per clock; after
// WIDTH bits the result lands in out with a one-cycle done pulse.
// WIDTH legal range is 2..32.
module compl_serial
    import compl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    compl_serial_if.slave        bus
);
    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};

    state_e           state_q;
    logic [WIDTH-1:0] sreg_q;
    logic [WIDTH-1:0] op_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_d;
    logic [CNT_W-1:0] cnt_q;
    logic             seen_q;
    logic             cpl_q;
    logic             tc_q;
    logic [WIDTH-1:0] out_q;
    logic             busy_q;
    logic             done_q;
    logic             ovf_q;

    logic             obit;
    logic             seen_nxt;

    compl_bit_cell u_cell (
        .b_i        (sreg_q[0]),
        .seen_i     (seen_q),
        .cpl_i      (cpl_q),
        .tc_i       (tc_q),
        .obit_o     (obit),
        .seen_nxt_o (seen_nxt)
    );

    // Result bits enter at the MSB so the first (LSB) bit ends up at res[0].
    assign res_d = {obit, res_q[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            op_q    <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            seen_q  <= 1'b0;
            cpl_q   <= 1'b0;
            tc_q    <= 1'b0;
            out_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q <= RUN;
                        sreg_q  <= bus.inp;
                        op_q    <= bus.inp;
                        cpl_q   <= bus.cpl;
                        tc_q    <= bus.tc;
                        res_q   <= '0;
                        cnt_q   <= '0;
                        seen_q  <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    sreg_q <= sreg_q >> 1;
                    seen_q <= seen_nxt;
                    res_q  <= res_d;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        out_q   <= res_d;
                        // Only 100..0 has no positive counterpart in WIDTH bits.
                        ovf_q   <= cpl_q & tc_q & (op_q == MSB_ONLY);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.out   = out_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.ovf   = ovf_q;
    assign bus.state = state_q;

endmodule

// File: tb/tb_compl_serial.sv
module tb_compl_serial;
    import compl_pkg::*;

    logic clk;
    logic rst_n;

    int total;
    int bad;

    logic [32:0] exp_q[$];      // {ovf, result} per outstanding operation
    logic [31:0] last_res[3];   // last completed result per instance

    compl_serial_if #(.WIDTH(4))  if4 ();
    compl_serial_if #(.WIDTH(8))  if8 ();
    compl_serial_if #(.WIDTH(32)) if32 ();

    compl_serial #(.WIDTH(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(if4));
    compl_serial #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
    compl_serial #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(if32));

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #10000000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    // Word-level: identity, bitwise NOT, or arithmetic negation modulo 2^w.
    task automatic ref_model(input int w, input logic [31:0] x, input logic c, input logic t,
                             output logic [31:0] res, output logic v);
        logic [63:0] mask;
        logic [63:0] xv;
        mask = (64'd1 << w) - 64'd1;
        xv   = {32'd0, x} & mask;
        if (!c)      res = xv[31:0];
        else if (!t) res = 32'((~xv) & mask);
        else         res = 32'((64'd0 - xv) & mask);
        v = c && t && (xv == (64'd1 << (w - 1)));
    endtask

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int widx(input int w);
        return (w == 4) ? 0 : (w == 8) ? 1 : 2;
    endfunction

    // ---------------- drivers ----------------
    task automatic drive(input int w, input logic s, input logic [31:0] x, input logic c, input logic t);
        case (w)
            4: begin if4.start = s; if4.inp = x[3:0]; if4.cpl = c; if4.tc = t; end
            8: begin if8.start = s; if8.inp = x[7:0]; if8.cpl = c; if8.tc = t; end
            default: begin if32.start = s; if32.inp = x; if32.cpl = c; if32.tc = t; end
        endcase
    endtask

    task automatic sample(input int w, output logic [31:0] o, output logic b, output logic d,
                          output logic v, output logic s);
        case (w)
            4: begin o = 32'(if4.out); b = if4.busy; d = if4.done; v = if4.ovf; s = if4.state; end
            8: begin o = 32'(if8.out); b = if8.busy; d = if8.done; v = if8.ovf; s = if8.state; end
            default: begin o = if32.out; b = if32.busy; d = if32.done; v = if32.ovf; s = if32.state; end
        endcase
    endtask

    // Call on a negedge: presents a request that the next rising edge accepts.
    task automatic start_op(input int w, input logic [31:0] x, input logic c, input logic t);
        logic [31:0] r;
        logic        v;
        ref_model(w, x, c, t, r, v);
        exp_q.push_back({v, r});
        drive(w, 1'b1, x, c, t);
    endtask

    // Waits for done after an accepted request and scores it. While busy the
    // request inputs are scrambled (start held when 'hold'), which must have
    // no effect. Returns on the done negedge with start low.
    task automatic finish_op(input int w, input logic hold);
        int          n;
        int          busy_cnt;
        logic        got_done;
        logic [31:0] o;
        logic        b, d, v, s;
        logic [32:0] e;
        n = 0; busy_cnt = 0; got_done = 1'b0;
        while (!got_done && n < 80) begin
            @(negedge clk);
            n++;
            sample(w, o, b, d, v, s);
            if (n == 1) begin
                check($sformatf("busy_on_accept_w%0d", w), 64'(b), 64'(1));
                check($sformatf("done_single_pulse_w%0d", w), 64'(d), 64'(0));
            end
            if (d) begin
                got_done = 1'b1;
            end else begin
                check($sformatf("out_held_w%0d", w), 64'(o), 64'(last_res[widx(w)]));
                if (b) busy_cnt++;
                drive(w, hold, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
        end
        e = exp_q.pop_front();
        if (!got_done) begin
            check($sformatf("done_timeout_w%0d", w), 64'(n), 64'(w + 1));
        end else begin
            check($sformatf("latency_w%0d", w), 64'(n - 1), 64'(w));
            check($sformatf("busy_cycles_w%0d", w), 64'(busy_cnt), 64'(w));
            check($sformatf("busy_at_done_w%0d", w), 64'(b), 64'(0));
            check($sformatf("out_w%0d", w), 64'(o), 64'(e[31:0]));
            check($sformatf("ovf_w%0d", w), 64'(v), 64'(e[32]));
            last_res[widx(w)] = e[31:0];
        end
        drive(w, 1'b0, $urandom, 1'b0, 1'b0);
    endtask

    task automatic run_op(input int w, input logic [31:0] x, input logic c, input logic t);
        @(negedge clk);
        start_op(w, x, c, t);
        finish_op(w, 1'b0);
    endtask

    task automatic check_idle(input int w, input string tag);
        logic [31:0] o;
        logic        b, d, v, s;
        sample(w, o, b, d, v, s);
        check($sformatf("%s_out_w%0d", tag, w), 64'(o), 64'(0));
        check($sformatf("%s_busy_w%0d", tag, w), 64'(b), 64'(0));
        check($sformatf("%s_done_w%0d", tag, w), 64'(d), 64'(0));
        check($sformatf("%s_ovf_w%0d", tag, w), 64'(v), 64'(0));
        check($sformatf("%s_state_w%0d", tag, w), 64'(s), 64'(IDLE));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] o;
        logic        b, d, v, s;
        logic [31:0] x;
        int          sel;
        total = 0; bad = 0;
        last_res[0] = '0; last_res[1] = '0; last_res[2] = '0;
        rst_n = 1'b0;
        drive(4, 1'b0, '0, 1'b0, 1'b0);
        drive(8, 1'b0, '0, 1'b0, 1'b0);
        drive(32, 1'b0, '0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check_idle(4, "reset"); check_idle(8, "reset"); check_idle(32, "reset");
        rst_n = 1'b1;

        // One's, two's, pass-through directed cases at WIDTH=4
        run_op(4, 32'b0101, 1'b1, 1'b0);
        run_op(4, 32'b0110, 1'b1, 1'b1);
        run_op(4, 32'b0000, 1'b1, 1'b1);
        run_op(4, 32'b1000, 1'b1, 1'b1);
        run_op(4, 32'b1011, 1'b0, 1'b1);

        // start held high with random inputs while busy, then restart on the done cycle
        @(negedge clk);
        start_op(4, 32'b1001, 1'b1, 1'b1);
        finish_op(4, 1'b1);
        start_op(4, 32'b0011, 1'b1, 1'b0);
        finish_op(4, 1'b1);
        start_op(4, 32'b1000, 1'b1, 1'b1);
        finish_op(4, 1'b0);
        start_op(4, 32'b1000, 1'b0, 1'b1);   // ovf must clear on a non-overflow done
        finish_op(4, 1'b0);

        // Reset two cycles into an operation
        @(negedge clk);
        start_op(4, 32'b0110, 1'b1, 1'b1);
        @(negedge clk);
        drive(4, 1'b0, 32'b0001, 1'b0, 1'b0);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check_idle(4, "async_reset");
        void'(exp_q.pop_back());
        last_res[0] = '0; last_res[1] = '0; last_res[2] = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            sample(4, o, b, d, v, s);
            check("no_done_after_abort", 64'(d), 64'(0));
            check("no_busy_after_abort", 64'(b), 64'(0));
        end
        run_op(4, 32'b0110, 1'b1, 1'b1);

        // Exhaustive WIDTH=4
        for (int i = 0; i < 16; i++)
            for (int m = 0; m < 4; m++)
                run_op(4, 32'(i), m[1], m[0]);

        // Random WIDTH=8 and WIDTH=32, biased toward 0 and the overflow pattern
        for (int k = 0; k < 2000; k++) begin
            int w;
            w   = (k < 1000) ? 8 : 32;
            sel = $urandom_range(0, 9);
            x   = $urandom;
            if (sel == 0)      x = 32'd1 << (w - 1);
            else if (sel == 1) x = '0;
            if (w == 8) x = x & 32'hFF;
            run_op(w, x, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
